reorder_buffer: RTL and testbench
=================================

Name: reorder_buffer

Overview:
- In-order retirement queue directly downstream of the reservation station and the load/store buffer.
- Allocates one entry per issued instruction and hands back its ROB id as the dependency tag.
- Snoops both result broadcasts (RS and LSB), supplies operand bypass to the issue stage, and retires one instruction per cycle at the head.
- On retirement of a mispredicted branch, flushes the whole pipeline and redirects fetch.

Parameters:
ROB_WIDTH_BIT, 4, log2 of entry count (16 entries); equals the codebase `ROB_WIDTH_BIT.

Ports:
clk_in  in  1  system clock
rst_n_in  in  1  reset, asynchronous, active-low
rdy_in  in  1  global ready; when low, all state holds
issue_valid  in  1  allocate one entry this cycle
issue_type  in  2  0=reg write, 1=store, 2=branch, 3=exit
issue_rd  in  5  destination register (type 0 only)
issue_done  in  1  result already known at issue (lui/auipc/jal)
issue_value  in  32  result when issue_done=1
issue_pred_taken  in  1  branch predictor decision
issue_alt_pc  in  32  fetch PC to use if the prediction is wrong
issue_rob_id  out  ROB_WIDTH_BIT  id allocated to the current issue (tail)
full  out  1  registered; no issue accepted next cycle
rs_ready, rs_rob_id, rs_value  in  1/ROB_WIDTH_BIT/32  RS result broadcast
lsb_ready, lsb_rob_id, lsb_value  in  1/ROB_WIDTH_BIT/32  LSB result broadcast
qry1_id, qry2_id  in  ROB_WIDTH_BIT  operand lookup ids
qry1_ready, qry2_ready  out  1  combinational: value available
qry1_value, qry2_value  out  32  combinational value
commit_valid  out  1  registered one-cycle retire pulse
commit_type  out  2  type of the retired entry
commit_rob_id  out  ROB_WIDTH_BIT  id of the retired entry
commit_rd  out  5  register to write (0 unless type 0)
commit_value  out  32  retired value
flush  out  1  registered one-cycle mispredict pulse
flush_pc  out  32  redirect target, valid when flush=1
halt  out  1  sticky; set when an exit entry retires

Behaviour:
- Reset (async, rst_n_in=0):
  - head=tail=0, count=0, all busy/done cleared.
  - full=0, commit_valid=0, commit_type=0, commit_rob_id=0, commit_rd=0, commit_value=0.
  - flush=0, flush_pc=0, halt=0.
  - Reset mid-operation discards all entries immediately.
- Circular buffer with pointers of ROB_WIDTH_BIT bits; wrap from 2^W-1 to 0 is natural overflow.
- Entry fields: busy, done, type, rd, value, pred_taken, alt_pc.
- issue_rob_id = tail, combinationally.
- Issue edge: entry[tail] is written with busy=1 and the incoming fields; tail increments.
  - done = issue_done OR a same-cycle broadcast match on tail.
  - Upstream must never assert issue_valid while full=1; the block's behaviour in that case is undefined.
- Writeback edge: for each busy entry whose id matches rs_rob_id or lsb_rob_id, set done=1 and capture the value.
  - If both broadcasts match the same id, lsb wins.
  - Matches on non-busy entries are ignored.
- Query (combinational): qryN_ready=1 if entry[qryN_id].done, or if a broadcast matches qryN_id this cycle (bypass, lsb priority).
  - qryN_value follows the same priority. Otherwise ready=0, value=0.
- Commit edge: if busy[head]&&done[head], clear busy[head], increment head, and pulse commit_valid with the entry's fields.
  - Otherwise commit_valid=0 that edge.
  - Latency: broadcast sampled at edge N gives commit_valid high in the cycle after edge N+1 (minimum 1 cycle from writeback to retire).
  - Entry issued with issue_done=1 at edge N may retire at edge N+1.
- Branch commit: taken = value[0].
  - If taken != pred_taken: flush=1, flush_pc=alt_pc, and at the same edge all entries are invalidated, head=tail=count=0, full=0.
  - The issue input is ignored on that edge; flush is high for exactly one cycle.
  - Correct prediction: retires normally with no flush.
- Exit commit: halt set to 1, stays 1 until reset; no further commits are performed.
- Count: next_count = count + issue − commit, clamped by the flush rule above.
  - full registered as next_count == 2^W; simultaneous issue and commit keeps count unchanged.
- rdy_in=0: pointers, entries, halt and full hold; commit_valid and flush are driven 0 at that edge.

Test Plan:
- Reset then issue reg-write rd=5, done=0, id 0; RS broadcast id 0 value 0x1234 -> next edge commit_valid=1, commit_rd=5, commit_value=0x1234, commit_rob_id=0.
- Issue 16 entries with no writeback -> full=1 after the 16th issue; writeback id 0, one commit -> full=0, count 15; issue with commit in one cycle keeps count 15; tail wraps 15->0.
- Out-of-order completion: ids 0,1,2 written back in order 2,1,0 -> commits occur strictly as 0,1,2 on consecutive cycles.
- Branch pred_taken=1, alt_pc=0x100, RS value 0 -> flush=1 for one cycle, flush_pc=0x100, younger entries never commit, next issue gets id 0.
- Query id 3 while lsb broadcasts id 3 value 0xdeadbeef in the same cycle -> qry1_ready=1, qry1_value=0xdeadbeef before the edge; simultaneous RS and LSB match on one id -> lsb value stored.
- rdy_in low for 3 cycles with a done head -> no commit, state frozen; async reset asserted mid-stream -> all outputs 0 immediately; exit entry retires -> halt=1 and stays 1.

Source files
------------

// File: rtl/reorder_buffer.sv
// In-order retirement queue: allocates ROB ids at issue, snoops RS/LSB results, bypasses operands, retires one entry per cycle.
// Latency: issue with a known result retires one edge later; a result broadcast retires no earlier than the edge after it is captured.
// Backpressure: registered full stops upstream issue; rdy_in low freezes all state and suppresses commit/flush pulses.
module reorder_buffer #(
    parameter int ROB_WIDTH_BIT = 4
) (
    input  logic                     clk_in,
    input  logic                     rst_n_in,
    input  logic                     rdy_in,
    // issue side
    input  logic                     issue_valid,
    input  logic [1:0]               issue_type,
    input  logic [4:0]               issue_rd,
    input  logic                     issue_done,
    input  logic [31:0]              issue_value,
    input  logic                     issue_pred_taken,
    input  logic [31:0]              issue_alt_pc,
    output logic [ROB_WIDTH_BIT-1:0] issue_rob_id,
    output logic                     full,
    // result broadcasts
    input  logic                     rs_ready,
    input  logic [ROB_WIDTH_BIT-1:0] rs_rob_id,
    input  logic [31:0]              rs_value,
    input  logic                     lsb_ready,
    input  logic [ROB_WIDTH_BIT-1:0] lsb_rob_id,
    input  logic [31:0]              lsb_value,
    // operand queries
    input  logic [ROB_WIDTH_BIT-1:0] qry1_id,
    input  logic [ROB_WIDTH_BIT-1:0] qry2_id,
    output logic                     qry1_ready,
    output logic [31:0]              qry1_value,
    output logic                     qry2_ready,
    output logic [31:0]              qry2_value,
    // retirement
    output logic                     commit_valid,
    output logic [1:0]               commit_type,
    output logic [ROB_WIDTH_BIT-1:0] commit_rob_id,
    output logic [4:0]               commit_rd,
    output logic [31:0]              commit_value,
    output logic                     flush,
    output logic [31:0]              flush_pc,
    output logic                     halt
);

    localparam int DEPTH = 1 << ROB_WIDTH_BIT;
    localparam int CNT_W = ROB_WIDTH_BIT + 1;

    localparam logic [1:0] T_REG    = 2'd0;
    localparam logic [1:0] T_BRANCH = 2'd2;
    localparam logic [1:0] T_EXIT   = 2'd3;

    typedef struct packed {
        logic        busy;
        logic        done;
        logic [1:0]  kind;
        logic [4:0]  rd;
        logic [31:0] value;
        logic        pred_taken;
        logic [31:0] alt_pc;
    } rob_entry_t;

    rob_entry_t               ent [DEPTH];
    logic [ROB_WIDTH_BIT-1:0] head;
    logic [ROB_WIDTH_BIT-1:0] tail;
    logic [CNT_W-1:0]         count;

    rob_entry_t       head_ent;
    logic             do_commit;
    logic             mispredict;
    logic             do_issue;
    logic [CNT_W-1:0] next_count;
    logic             iss_done;
    logic [31:0]      iss_value;

    assign issue_rob_id = tail;

    // Retire/flush/issue decisions for this edge; a mispredict kills the same-edge issue.
    always_comb begin
        head_ent   = ent[head];
        do_commit  = rdy_in && !halt && head_ent.busy && head_ent.done;
        mispredict = do_commit && (head_ent.kind == T_BRANCH) &&
                     (head_ent.value[0] != head_ent.pred_taken);
        do_issue   = rdy_in && issue_valid && !mispredict;
        if (mispredict) begin
            next_count = '0;
        end else begin
            next_count = count + CNT_W'(do_issue) - CNT_W'(do_commit);
        end
    end

    // Result for the entry being allocated: known at issue, or caught from a same-cycle broadcast (lsb first).
    always_comb begin
        iss_done  = issue_done;
        iss_value = issue_value;
        if (!issue_done) begin
            if (lsb_ready && (lsb_rob_id == tail)) begin
                iss_done  = 1'b1;
                iss_value = lsb_value;
            end else if (rs_ready && (rs_rob_id == tail)) begin
                iss_done  = 1'b1;
                iss_value = rs_value;
            end
        end
    end

    // Operand lookup: live broadcast bypass (lsb first), then a completed entry, else not ready.
    always_comb begin
        qry1_ready = 1'b0;
        qry1_value = '0;
        qry2_ready = 1'b0;
        qry2_value = '0;
        if (lsb_ready && (lsb_rob_id == qry1_id)) begin
            qry1_ready = 1'b1;
            qry1_value = lsb_value;
        end else if (rs_ready && (rs_rob_id == qry1_id)) begin
            qry1_ready = 1'b1;
            qry1_value = rs_value;
        end else if (ent[qry1_id].done) begin
            qry1_ready = 1'b1;
            qry1_value = ent[qry1_id].value;
        end
        if (lsb_ready && (lsb_rob_id == qry2_id)) begin
            qry2_ready = 1'b1;
            qry2_value = lsb_value;
        end else if (rs_ready && (rs_rob_id == qry2_id)) begin
            qry2_ready = 1'b1;
            qry2_value = rs_value;
        end else if (ent[qry2_id].done) begin
            qry2_ready = 1'b1;
            qry2_value = ent[qry2_id].value;
        end
    end

    // Entry storage: writeback capture on busy entries, retire clears busy at head, issue fills tail; flush wipes all.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            for (int i = 0; i < DEPTH; i++) begin
                ent[i] <= '0;
            end
        end else if (rdy_in) begin
            if (mispredict) begin
                for (int i = 0; i < DEPTH; i++) begin
                    ent[i].busy <= 1'b0;
                    ent[i].done <= 1'b0;
                end
            end else begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (ent[i].busy) begin
                        if (lsb_ready && (lsb_rob_id == ROB_WIDTH_BIT'(i))) begin
                            ent[i].done  <= 1'b1;
                            ent[i].value <= lsb_value;
                        end else if (rs_ready && (rs_rob_id == ROB_WIDTH_BIT'(i))) begin
                            ent[i].done  <= 1'b1;
                            ent[i].value <= rs_value;
                        end
                    end
                end
                if (do_commit) begin
                    ent[head].busy <= 1'b0;
                end
                if (do_issue) begin
                    ent[tail] <= '{busy:       1'b1,
                                   done:       iss_done,
                                   kind:       issue_type,
                                   rd:         issue_rd,
                                   value:      iss_value,
                                   pred_taken: issue_pred_taken,
                                   alt_pc:     issue_alt_pc};
                end
            end
        end
    end

    // Pointers, occupancy and the registered full flag.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            full  <= 1'b0;
        end else if (rdy_in) begin
            if (mispredict) begin
                head <= '0;
                tail <= '0;
            end else begin
                head <= head + ROB_WIDTH_BIT'(do_commit);
                tail <= tail + ROB_WIDTH_BIT'(do_issue);
            end
            count <= next_count;
            full  <= (next_count == CNT_W'(DEPTH));
        end
    end

    // Retire and redirect pulses; payload fields hold their last value between retirements.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            commit_valid  <= 1'b0;
            commit_type   <= '0;
            commit_rob_id <= '0;
            commit_rd     <= '0;
            commit_value  <= '0;
            flush         <= 1'b0;
            flush_pc      <= '0;
        end else begin
            commit_valid <= 1'b0;
            flush        <= 1'b0;
            if (do_commit) begin
                commit_valid  <= 1'b1;
                commit_type   <= head_ent.kind;
                commit_rob_id <= head;
                commit_rd     <= (head_ent.kind == T_REG) ? head_ent.rd : 5'd0;
                commit_value  <= head_ent.value;
            end
            if (mispredict) begin
                flush    <= 1'b1;
                flush_pc <= head_ent.alt_pc;
            end
        end
    end

    // Sticky halt once an exit entry retires; it also blocks any later retirement.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            halt <= 1'b0;
        end else if (do_commit && (head_ent.kind == T_EXIT)) begin
            halt <= 1'b1;
        end
    end

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed bench for reorder_buffer: allocation, writeback, ordering, flush, bypass, hold, reset, halt.
// Latency: checks registered outputs #1 after the clock edge and combinational queries before the edge.
// Backpressure: exercises full, rdy_in hold and issue suppression on flush.
module tb_reorder_buffer;

    logic        clk_in;
    logic        rst_n_in;
    logic        rdy_in;
    logic        issue_valid;
    logic [1:0]  issue_type;
    logic [4:0]  issue_rd;
    logic        issue_done;
    logic [31:0] issue_value;
    logic        issue_pred_taken;
    logic [31:0] issue_alt_pc;
    logic [3:0]  issue_rob_id;
    logic        full;
    logic        rs_ready;
    logic [3:0]  rs_rob_id;
    logic [31:0] rs_value;
    logic        lsb_ready;
    logic [3:0]  lsb_rob_id;
    logic [31:0] lsb_value;
    logic [3:0]  qry1_id;
    logic [3:0]  qry2_id;
    logic        qry1_ready;
    logic [31:0] qry1_value;
    logic        qry2_ready;
    logic [31:0] qry2_value;
    logic        commit_valid;
    logic [1:0]  commit_type;
    logic [3:0]  commit_rob_id;
    logic [4:0]  commit_rd;
    logic [31:0] commit_value;
    logic        flush;
    logic [31:0] flush_pc;
    logic        halt;

    int n_checks = 0;
    int n_fail   = 0;

    reorder_buffer #(.ROB_WIDTH_BIT(4)) dut (
        .clk_in(clk_in), .rst_n_in(rst_n_in), .rdy_in(rdy_in),
        .issue_valid(issue_valid), .issue_type(issue_type), .issue_rd(issue_rd),
        .issue_done(issue_done), .issue_value(issue_value),
        .issue_pred_taken(issue_pred_taken), .issue_alt_pc(issue_alt_pc),
        .issue_rob_id(issue_rob_id), .full(full),
        .rs_ready(rs_ready), .rs_rob_id(rs_rob_id), .rs_value(rs_value),
        .lsb_ready(lsb_ready), .lsb_rob_id(lsb_rob_id), .lsb_value(lsb_value),
        .qry1_id(qry1_id), .qry2_id(qry2_id),
        .qry1_ready(qry1_ready), .qry1_value(qry1_value),
        .qry2_ready(qry2_ready), .qry2_value(qry2_value),
        .commit_valid(commit_valid), .commit_type(commit_type),
        .commit_rob_id(commit_rob_id), .commit_rd(commit_rd), .commit_value(commit_value),
        .flush(flush), .flush_pc(flush_pc), .halt(halt)
    );

    initial begin
        clk_in = 1'b0;
        forever #5 clk_in = ~clk_in;
    end

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic clear_inputs();
        issue_valid = 1'b0; issue_type = 2'd0; issue_rd = 5'd0; issue_done = 1'b0;
        issue_value = 32'd0; issue_pred_taken = 1'b0; issue_alt_pc = 32'd0;
        rs_ready = 1'b0; rs_rob_id = 4'd0; rs_value = 32'd0;
        lsb_ready = 1'b0; lsb_rob_id = 4'd0; lsb_value = 32'd0;
    endtask

    task automatic set_issue(input logic [1:0] k, input logic [4:0] rd, input logic d,
                             input logic [31:0] v, input logic p, input logic [31:0] alt);
        issue_valid = 1'b1; issue_type = k; issue_rd = rd; issue_done = d;
        issue_value = v; issue_pred_taken = p; issue_alt_pc = alt;
    endtask

    task automatic do_reset();
        clear_inputs();
        rdy_in = 1'b1;
        rst_n_in = 1'b0;
        step();
        rst_n_in = 1'b1;
    endtask

    task automatic test_reset();
        clear_inputs();
        rdy_in = 1'b1; qry1_id = 4'd0; qry2_id = 4'd0;
        rst_n_in = 1'b1;
        #2 rst_n_in = 1'b0;
        #2;
        n_checks++; if (full !== 1'b0) begin n_fail++; $display("FAIL rst_full got=%0h want=0", full); end
        n_checks++; if (commit_valid !== 1'b0) begin n_fail++; $display("FAIL rst_cv got=%0h want=0", commit_valid); end
        n_checks++; if (commit_value !== 32'd0) begin n_fail++; $display("FAIL rst_cvalue got=%0h want=0", commit_value); end
        n_checks++; if (commit_rd !== 5'd0) begin n_fail++; $display("FAIL rst_crd got=%0h want=0", commit_rd); end
        n_checks++; if (flush !== 1'b0 || flush_pc !== 32'd0) begin n_fail++; $display("FAIL rst_flush got=%0h/%0h want=0/0", flush, flush_pc); end
        n_checks++; if (halt !== 1'b0) begin n_fail++; $display("FAIL rst_halt got=%0h want=0", halt); end
        n_checks++; if (issue_rob_id !== 4'd0) begin n_fail++; $display("FAIL rst_id got=%0h want=0", issue_rob_id); end
        n_checks++; if (qry1_ready !== 1'b0) begin n_fail++; $display("FAIL rst_qry got=%0h want=0", qry1_ready); end
        step();
        rst_n_in = 1'b1;
    endtask

    task automatic test_basic();
        do_reset();
        set_issue(2'd0, 5'd5, 1'b0, 32'd0, 1'b0, 32'd0);
        #1;
        n_checks++; if (issue_rob_id !== 4'd0) begin n_fail++; $display("FAIL basic_id got=%0h want=0", issue_rob_id); end
        step();
        clear_inputs();
        rs_ready = 1'b1; rs_rob_id = 4'd0; rs_value = 32'h1234;
        step();
        n_checks++; if (commit_valid !== 1'b0) begin n_fail++; $display("FAIL basic_early got=%0h want=0", commit_valid); end
        clear_inputs();
        step();
        n_checks++; if (commit_valid !== 1'b1) begin n_fail++; $display("FAIL basic_cv got=%0h want=1", commit_valid); end
        n_checks++; if (commit_rd !== 5'd5) begin n_fail++; $display("FAIL basic_rd got=%0h want=5", commit_rd); end
        n_checks++; if (commit_value !== 32'h1234) begin n_fail++; $display("FAIL basic_value got=%0h want=1234", commit_value); end
        n_checks++; if (commit_rob_id !== 4'd0 || commit_type !== 2'd0) begin n_fail++; $display("FAIL basic_idtype got=%0h/%0h want=0/0", commit_rob_id, commit_type); end
        step();
        n_checks++; if (commit_valid !== 1'b0) begin n_fail++; $display("FAIL basic_single got=%0h want=0", commit_valid); end
    endtask

    task automatic test_full();
        do_reset();
        for (int i = 0; i < 16; i++) begin
            set_issue(2'd0, 5'(i), 1'b0, 32'd0, 1'b0, 32'd0);
            step();
            if (i == 14) begin
                n_checks++; if (full !== 1'b0) begin n_fail++; $display("FAIL full_15 got=%0h want=0", full); end
            end
        end
        clear_inputs();
        n_checks++; if (full !== 1'b1) begin n_fail++; $display("FAIL full_16 got=%0h want=1", full); end
        n_checks++; if (issue_rob_id !== 4'd0) begin n_fail++; $display("FAIL full_wrap got=%0h want=0", issue_rob_id); end
        rs_ready = 1'b1; rs_rob_id = 4'd0; rs_value = 32'hA0;
        step();
        n_checks++; if (full !== 1'b1 || commit_valid !== 1'b0) begin n_fail++; $display("FAIL full_wb got=%0h/%0h want=1/0", full, commit_valid); end
        rs_rob_id = 4'd1; rs_value = 32'hA1;
        step();
        n_checks++; if (commit_valid !== 1'b1 || commit_rob_id !== 4'd0) begin n_fail++; $display("FAIL full_c0 got=%0h/%0h want=1/0", commit_valid, commit_rob_id); end
        n_checks++; if (full !== 1'b0) begin n_fail++; $display("FAIL full_drop got=%0h want=0", full); end
        clear_inputs();
        set_issue(2'd0, 5'd20, 1'b0, 32'd0, 1'b0, 32'd0);
        step();
        n_checks++; if (commit_valid !== 1'b1 || commit_rob_id !== 4'd1) begin n_fail++; $display("FAIL full_c1 got=%0h/%0h want=1/1", commit_valid, commit_rob_id); end
        n_checks++; if (full !== 1'b0 || issue_rob_id !== 4'd1) begin n_fail++; $display("FAIL full_same got=%0h/%0h want=0/1", full, issue_rob_id); end
        step();
        n_checks++; if (full !== 1'b1 || commit_valid !== 1'b0) begin n_fail++; $display("FAIL full_refill got=%0h/%0h want=1/0", full, commit_valid); end
        clear_inputs();
    endtask

    task automatic test_out_of_order();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            set_issue(2'd0, 5'(i + 1), 1'b0, 32'd0, 1'b0, 32'd0);
            step();
        end
        clear_inputs();
        rs_ready = 1'b1; rs_rob_id = 4'd2; rs_value = 32'h22;
        step();
        n_checks++; if (commit_valid !== 1'b0) begin n_fail++; $display("FAIL ooo_wb2 got=%0h want=0", commit_valid); end
        clear_inputs();
        lsb_ready = 1'b1; lsb_rob_id = 4'd1; lsb_value = 32'h11;
        step();
        n_checks++; if (commit_valid !== 1'b0) begin n_fail++; $display("FAIL ooo_wb1 got=%0h want=0", commit_valid); end
        clear_inputs();
        rs_ready = 1'b1; rs_rob_id = 4'd0; rs_value = 32'h10;
        step();
        n_checks++; if (commit_valid !== 1'b0) begin n_fail++; $display("FAIL ooo_wb0 got=%0h want=0", commit_valid); end
        clear_inputs();
        step();
        n_checks++; if (commit_valid !== 1'b1 || commit_rob_id !== 4'd0 || commit_value !== 32'h10 || commit_rd !== 5'd1) begin n_fail++; $display("FAIL ooo_c0 got=%0h/%0h/%0h/%0h want=1/0/10/1", commit_valid, commit_rob_id, commit_value, commit_rd); end
        step();
        n_checks++; if (commit_valid !== 1'b1 || commit_rob_id !== 4'd1 || commit_value !== 32'h11 || commit_rd !== 5'd2) begin n_fail++; $display("FAIL ooo_c1 got=%0h/%0h/%0h/%0h want=1/1/11/2", commit_valid, commit_rob_id, commit_value, commit_rd); end
        step();
        n_checks++; if (commit_valid !== 1'b1 || commit_rob_id !== 4'd2 || commit_value !== 32'h22 || commit_rd !== 5'd3) begin n_fail++; $display("FAIL ooo_c2 got=%0h/%0h/%0h/%0h want=1/2/22/3", commit_valid, commit_rob_id, commit_value, commit_rd); end
        step();
        n_checks++; if (commit_valid !== 1'b0) begin n_fail++; $display("FAIL ooo_end got=%0h want=0", commit_valid); end
    endtask

    task automatic test_branch();
        do_reset();
        // correctly predicted not-taken branch
        set_issue(2'd2, 5'd9, 1'b1, 32'd0, 1'b0, 32'h200);
        step();
        clear_inputs();
        step();
        n_checks++; if (commit_valid !== 1'b1 || commit_type !== 2'd2 || commit_rd !== 5'd0) begin n_fail++; $display("FAIL br_ok got=%0h/%0h/%0h want=1/2/0", commit_valid, commit_type, commit_rd); end
        n_checks++; if (flush !== 1'b0) begin n_fail++; $display("FAIL br_ok_flush got=%0h want=0", flush); end
        // mispredicted: predicted taken, resolves not taken
        set_issue(2'd2, 5'd0, 1'b0, 32'd0, 1'b1, 32'h100);
        step();
        set_issue(2'd0, 5'd4, 1'b1, 32'h44, 1'b0, 32'd0);
        step();
        set_issue(2'd0, 5'd6, 1'b1, 32'h66, 1'b0, 32'd0);
        step();
        clear_inputs();
        rs_ready = 1'b1; rs_rob_id = 4'd1; rs_value = 32'd0;
        step();
        clear_inputs();
        set_issue(2'd0, 5'd8, 1'b1, 32'h88, 1'b0, 32'd0);
        step();
        n_checks++; if (flush !== 1'b1 || flush_pc !== 32'h100) begin n_fail++; $display("FAIL br_flush got=%0h/%0h want=1/100", flush, flush_pc); end
        n_checks++; if (issue_rob_id !== 4'd0 || full !== 1'b0) begin n_fail++; $display("FAIL br_ptr got=%0h/%0h want=0/0", issue_rob_id, full); end
        clear_inputs();
        step();
        n_checks++; if (flush !== 1'b0 || commit_valid !== 1'b0) begin n_fail++; $display("FAIL br_after got=%0h/%0h want=0/0", flush, commit_valid); end
        step();
        n_checks++; if (commit_valid !== 1'b0) begin n_fail++; $display("FAIL br_young got=%0h want=0", commit_valid); end
        set_issue(2'd0, 5'd7, 1'b1, 32'h55, 1'b0, 32'd0);
        step();
        clear_inputs();
        step();
        n_checks++; if (commit_valid !== 1'b1 || commit_rob_id !== 4'd0 || commit_value !== 32'h55 || commit_rd !== 5'd7) begin n_fail++; $display("FAIL br_new got=%0h/%0h/%0h/%0h want=1/0/55/7", commit_valid, commit_rob_id, commit_value, commit_rd); end
    endtask

    task automatic test_bypass();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            set_issue(2'd0, 5'(i + 10), 1'b0, 32'd0, 1'b0, 32'd0);
            step();
        end
        clear_inputs();
        qry1_id = 4'd3; qry2_id = 4'd2;
        lsb_ready = 1'b1; lsb_rob_id = 4'd3; lsb_value = 32'hdeadbeef;
        rs_ready = 1'b1; rs_rob_id = 4'd3; rs_value = 32'h1111;
        #1;
        n_checks++; if (qry1_ready !== 1'b1 || qry1_value !== 32'hdeadbeef) begin n_fail++; $display("FAIL byp_lsb got=%0h/%0h want=1/deadbeef", qry1_ready, qry1_value); end
        n_checks++; if (qry2_ready !== 1'b0 || qry2_value !== 32'd0) begin n_fail++; $display("FAIL byp_none got=%0h/%0h want=0/0", qry2_ready, qry2_value); end
        step();
        clear_inputs();
        rs_ready = 1'b1; rs_rob_id = 4'd2; rs_value = 32'h2222;
        #1;
        n_checks++; if (qry1_ready !== 1'b1 || qry1_value !== 32'hdeadbeef) begin n_fail++; $display("FAIL byp_stored got=%0h/%0h want=1/deadbeef", qry1_ready, qry1_value); end
        n_checks++; if (qry2_ready !== 1'b1 || qry2_value !== 32'h2222) begin n_fail++; $display("FAIL byp_rs got=%0h/%0h want=1/2222", qry2_ready, qry2_value); end
        clear_inputs();
        lsb_ready = 1'b1; lsb_rob_id = 4'd9; lsb_value = 32'h99;
        step();
        clear_inputs();
        qry1_id = 4'd9;
        #1;
        n_checks++; if (qry1_ready !== 1'b0) begin n_fail++; $display("FAIL byp_nonbusy got=%0h want=0", qry1_ready); end
        qry1_id = 4'd0; qry2_id = 4'd0;
    endtask

    task automatic test_rdy_hold();
        do_reset();
        set_issue(2'd0, 5'd3, 1'b1, 32'h77, 1'b0, 32'd0);
        step();
        clear_inputs();
        rdy_in = 1'b0;
        set_issue(2'd0, 5'd4, 1'b1, 32'h88, 1'b0, 32'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            n_checks++; if (commit_valid !== 1'b0 || issue_rob_id !== 4'd1) begin n_fail++; $display("FAIL hold_%0d got=%0h/%0h want=0/1", i, commit_valid, issue_rob_id); end
        end
        clear_inputs();
        rdy_in = 1'b1;
        step();
        n_checks++; if (commit_valid !== 1'b1 || commit_value !== 32'h77 || commit_rob_id !== 4'd0 || commit_rd !== 5'd3) begin n_fail++; $display("FAIL hold_release got=%0h/%0h/%0h/%0h want=1/77/0/3", commit_valid, commit_value, commit_rob_id, commit_rd); end
        step();
        n_checks++; if (commit_valid !== 1'b0) begin n_fail++; $display("FAIL hold_dropped got=%0h want=0", commit_valid); end
    endtask

    task automatic test_async_reset();
        do_reset();
        set_issue(2'd0, 5'd1, 1'b1, 32'h31, 1'b0, 32'd0);
        step();
        set_issue(2'd0, 5'd2, 1'b1, 32'h32, 1'b0, 32'd0);
        step();
        clear_inputs();
        n_checks++; if (commit_valid !== 1'b1 || commit_value !== 32'h31) begin n_fail++; $display("FAIL ar_pre got=%0h/%0h want=1/31", commit_valid, commit_value); end
        #2 rst_n_in = 1'b0;
        #1;
        n_checks++; if (commit_valid !== 1'b0 || commit_value !== 32'd0 || commit_rd !== 5'd0) begin n_fail++; $display("FAIL ar_commit got=%0h/%0h/%0h want=0/0/0", commit_valid, commit_value, commit_rd); end
        n_checks++; if (issue_rob_id !== 4'd0 || full !== 1'b0 || halt !== 1'b0) begin n_fail++; $display("FAIL ar_state got=%0h/%0h/%0h want=0/0/0", issue_rob_id, full, halt); end
        #1 rst_n_in = 1'b1;
        step();
        n_checks++; if (commit_valid !== 1'b0) begin n_fail++; $display("FAIL ar_discard got=%0h want=0", commit_valid); end
    endtask

    task automatic test_halt();
        do_reset();
        set_issue(2'd3, 5'd0, 1'b1, 32'd0, 1'b0, 32'd0);
        step();
        set_issue(2'd0, 5'd5, 1'b1, 32'h5, 1'b0, 32'd0);
        step();
        clear_inputs();
        n_checks++; if (halt !== 1'b1 || commit_valid !== 1'b1 || commit_type !== 2'd3) begin n_fail++; $display("FAIL halt_set got=%0h/%0h/%0h want=1/1/3", halt, commit_valid, commit_type); end
        step();
        n_checks++; if (halt !== 1'b1 || commit_valid !== 1'b0) begin n_fail++; $display("FAIL halt_stop got=%0h/%0h want=1/0", halt, commit_valid); end
        step();
        n_checks++; if (halt !== 1'b1 || commit_valid !== 1'b0) begin n_fail++; $display("FAIL halt_sticky got=%0h/%0h want=1/0", halt, commit_valid); end
        do_reset();
        n_checks++; if (halt !== 1'b0) begin n_fail++; $display("FAIL halt_reset got=%0h want=0", halt); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_full();
        test_out_of_order();
        test_branch();
        test_bypass();
        test_rdy_hold();
        test_async_reset();
        test_halt();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
